// File: rtl/hilo_div_if.sv
// EX-stage <-> divider handshake and HI/LO write bus.
// div_bus = {hi_we, lo_we, hi_in, lo_in}; the EX side is master.
interface hilo_div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_op;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 annul;
    logic                 stallreq;
    logic                 ready;
    logic [2*WIDTH+1:0]   div_bus;

    modport master (
        output start, signed_op, opdata1, opdata2, annul,
        input  stallreq, ready, div_bus
    );

    modport slave (
        input  start, signed_op, opdata1, opdata2, annul,
        output stallreq, ready, div_bus
    );
endinterface

// File: rtl/hilo_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU; quotient -> LO, remainder -> HI.
// Optional HILO_DIV_ZERO_FAST_EN: a zero divisor skips the iterations (IDLE -> DONE).
module hilo_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    hilo_div_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_accept;
    logic               w_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_out;
    logic [WIDTH-1:0]   w_rem_out;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.annul;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef HILO_DIV_ZERO_FAST_EN
    assign w_zero = (bus.opdata2 == '0);
`else
    assign w_zero = 1'b0;
`endif

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign w_a_mag = (bus.signed_op && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    assign w_b_mag = (bus.signed_op && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

    // Non-negative when the shifted value carries bit WIDTH (it then exceeds any
    // divisor) or the 33-bit difference shows no borrow.
    assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_qbit   = w_shift[WIDTH] || !w_diff[WIDTH];
    assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

    assign w_quo_out = r_neg_q ? -r_dvd : r_dvd;
    assign w_rem_out = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.stallreq = 1'b0;
        bus.ready    = 1'b0;
        bus.div_bus  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    bus.stallreq = 1'b1;
                    w_next       = w_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (bus.annul) begin
                    w_next = IDLE;
                end else begin
                    bus.stallreq = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
                if (!bus.annul) begin
                    bus.ready   = 1'b1;
                    bus.div_bus = {2'b11, w_rem_out, w_quo_out};
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // r_dvd holds the dividend magnitude and fills with quotient bits from the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= bus.signed_op && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        r_neg_r <= bus.signed_op && bus.opdata1[WIDTH-1];
                        if (w_zero) begin
                            r_dvd <= '1;
                            r_rem <= w_a_mag;
                        end else begin
                            r_dvd <= w_a_mag;
                            r_rem <= '0;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_rem <= w_rem_nx;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div.sv
// Randomized and directed bench for hilo_div against an arithmetic reference model.
module tb_hilo_div;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hilo_div_if #(.WIDTH(32)) dif ();

    hilo_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] lo, hi;
        if (b == 0) begin
            hi = a;
            lo = (s && $signed(a) < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
        return {2'b11, hi, lo};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef HILO_DIV_ZERO_FAST_EN
        return (b == 0) ? 1 : 33;
`else
        return (b == 0) ? 33 : 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'h0;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return -32'($urandom_range(1, 100));
        endcase
    endfunction

    // Start is held until the cycle after DONE, as EX does while stalled.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        int           cyc;
        int           stall_cnt;
        logic         got;
        logic         viol;
        logic [65:0]  bus_seen;
        @(posedge clk);
        #1;
        dif.start     = 1'b1;
        dif.signed_op = s;
        dif.opdata1   = a;
        dif.opdata2   = b;
        dif.annul     = 1'b0;
        cyc       = 0;
        stall_cnt = 0;
        got       = 1'b0;
        viol      = 1'b0;
        bus_seen  = '0;
        while (!got && cyc <= 100) begin
            @(negedge clk);
            if (dif.stallreq) stall_cnt++;
            viol = viol | (dif.ready & dif.stallreq);
            if (dif.ready) begin
                got      = 1'b1;
                bus_seen = dif.div_bus;
            end else begin
                cyc++;
            end
        end
        check_eq({tag, ".ready_seen"}, 66'(got), 66'd1);
        check_eq({tag, ".latency"}, 66'(cyc), 66'(ref_lat(b)));
        check_eq({tag, ".stall_cycles"}, 66'(stall_cnt), 66'(ref_lat(b)));
        check_eq({tag, ".bus"}, bus_seen, ref_div(s, a, b));
        check_eq({tag, ".ready_vs_stall"}, 66'(viol), 66'd0);
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        @(negedge clk);
        check_eq({tag, ".after_done"}, {dif.ready, dif.stallreq, dif.div_bus[63:0]}, 66'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        dif.start     = 1'b0;
        dif.signed_op = 1'b0;
        dif.opdata1   = '0;
        dif.opdata2   = '0;
        dif.annul     = 1'b0;

        #12;
        check_eq("reset.stallreq", 66'(dif.stallreq), 66'd0);
        check_eq("reset.ready", 66'(dif.ready), 66'd0);
        check_eq("reset.bus", dif.div_bus, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        do_div(1'b0, 32'h1234_5678, 32'd0, "divu_by0");
        do_div(1'b1, 32'hFFFF_FFF0, 32'd0, "div_neg_by0");

        // Flush in BUSY cycle 10, then a fresh request on the next cycle.
        @(posedge clk);
        #1;
        dif.start     = 1'b1;
        dif.signed_op = 1'b0;
        dif.opdata1   = 32'd50;
        dif.opdata2   = 32'd5;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        dif.annul = 1'b1;
        dif.start = 1'b0;
        #1;
        check_eq("annul.stallreq", 66'(dif.stallreq), 66'd0);
        check_eq("annul.ready", 66'(dif.ready), 66'd0);
        check_eq("annul.bus", dif.div_bus, 66'd0);
        do_div(1'b0, 32'd9, 32'd3, "after_annul");

        // Asynchronous reset in the middle of an operation.
        @(posedge clk);
        #1;
        dif.start     = 1'b1;
        dif.signed_op = 1'b0;
        dif.opdata1   = 32'd1000;
        dif.opdata2   = 32'd3;
        repeat (6) @(posedge clk);
        #3;
        dif.start = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("midreset.stallreq", 66'(dif.stallreq), 66'd0);
        check_eq("midreset.ready", 66'(dif.ready), 66'd0);
        check_eq("midreset.bus", dif.div_bus, 66'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_div(1'b0, 32'd1, 32'd1, "after_reset");

        for (int i = 0; i < 30; i++) begin
            logic        s;
            logic [31:0] a;
            logic [31:0] b;
            s = 1'($urandom_range(0, 1));
            a = pick_operand();
            b = pick_operand();
            do_div(s, a, b, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
